// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the UART transmit arbiter.
//   arb_state_e    : arbiter FSM states (IDLE, LOCK)
//   *_DEF          : default parameter values for the arbiter top
//   idx_width(n)   : bit width needed to hold an index in 0..n-1 (minimum 1)
// ----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF    = 1024;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches i_req upward starting at
// i_last_grant+1 (wrapping modulo N_REQ) and returns the first set index.
// Ports:
//   i_req        [N_REQ-1:0] request vector
//   i_last_grant [IW-1:0]    most recently served index (lowest priority)
//   o_found                  any request present
//   o_idx        [IW-1:0]    selected index (0 when o_found=0)
// ----------------------------------------------------------------------------
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_last_grant,
    output logic             o_found,
    output logic [IW-1:0]    o_idx
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        o_found = 1'b0;
        o_idx   = '0;
        // Indices at or below last_grant are the wrapped tail of the search
        // order, so they are scanned first and overridden by any hit above
        // last_grant. Each loop runs downward so the lowest index wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i] && (i <= int'(i_last_grant))) begin
                o_found = 1'b1;
                o_idx   = IW'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i] && (i > int'(i_last_grant))) begin
                o_found = 1'b1;
                o_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Packet-granular round-robin arbiter sharing one TX FIFO write port among
// N_REQ byte producers. The owner keeps the port until it transfers a byte
// flagged last, so packets never interleave. One dead cycle per packet is
// spent in IDLE choosing the next owner.
// Optional build macro: UART_ARB_TIMEOUT_EN -- releases a lock whose owner
// has been silent (valid low, FIFO not full) for TIMEOUT_CYCLES cycles and
// adds the timeout_evt output.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/last[N_REQ] per-requester byte valid / last-byte flag
//   req_data              packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready[N_REQ]      per-requester accept (one-hot or zero)
//   tx_full               TX FIFO full
//   wr_uart, w_data       TX FIFO write strobe and data
//   grant_id              current or most recent owner
//   busy                  packet lock held
//   timeout_evt           one-cycle pulse on timeout release (macro only)
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = N_REQ_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        tx_full,
    output logic                        wr_uart,
    output logic [DATA_WIDTH-1:0]       w_data,
    output logic [idx_width(N_REQ)-1:0] grant_id,
    output logic                        busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                        timeout_evt
`endif
);

    localparam int IW = idx_width(N_REQ);

    arb_state_e            r_state, w_state_nxt;
    logic [IW-1:0]         r_owner, w_owner_nxt;
    logic [IW-1:0]         r_last_grant, w_last_grant_nxt;
    logic                  w_pick_found;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_found      (w_pick_found),
        .o_idx        (w_pick_idx)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic          r_timeout_evt, w_timeout_nxt;
    assign timeout_evt = r_timeout_evt;
`endif

    // ---------------- next-state and outputs ----------------
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        req_ready        = '0;
        wr_uart          = 1'b0;
        w_data           = '0;
        w_xfer           = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        w_idle_cnt_nxt   = r_idle_cnt;
        w_timeout_nxt    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_owner_nxt = w_pick_idx;
                    w_state_nxt = LOCK;
`ifdef UART_ARB_TIMEOUT_EN
                    w_idle_cnt_nxt = '0;
`endif
                end
            end
            LOCK: begin
                req_ready[r_owner] = ~tx_full;
                w_xfer             = req_valid[r_owner] & ~tx_full;
                wr_uart            = w_xfer;
                w_data             = w_bytes[r_owner];
                if (w_xfer && req_last[r_owner]) begin
                    w_last_grant_nxt = r_owner;
                    w_state_nxt      = IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                if (w_xfer) begin
                    w_idle_cnt_nxt = '0;
                end else if (!tx_full) begin
                    // Release on the silent cycle that would bring the count
                    // to TIMEOUT_CYCLES; the counter itself never holds it.
                    if (r_idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        w_idle_cnt_nxt   = '0;
                        w_timeout_nxt    = 1'b1;
                        w_last_grant_nxt = r_owner;
                        w_state_nxt      = IDLE;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                    end
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_grant <= IW'(N_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            r_idle_cnt    <= '0;
            r_timeout_evt <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            r_idle_cnt    <= w_idle_cnt_nxt;
            r_timeout_evt <= w_timeout_nxt;
`endif
        end
    end

    assign busy     = (r_state == LOCK);
    assign grant_id = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N_REQ=4, DATA_WIDTH=8). Inputs are
// driven 1 ns after the rising edge, outputs checked on the falling edge.
// A negedge monitor records every byte the FIFO would accept.
// With UART_ARB_TIMEOUT_EN defined the DUT uses TIMEOUT_CYCLES=8 and the
// timeout sequence is exercised as well.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_last = '0;
    logic [N-1:0]      req_ready;
    logic              tx_full = 1'b0;
    logic              wr_uart;
    logic [DW-1:0]     w_data;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic              timeout_evt;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] fifo_q [$];

    uart_tx_arbiter #(
        .N_REQ          (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_full     (tx_full),
        .wr_uart     (wr_uart),
        .w_data      (w_data),
        .grant_id    (grant_id),
        .busy        (busy)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_evt (timeout_evt)
`endif
    );

    always #5 clk = ~clk;

    // Bytes the FIFO samples on the following rising edge.
    always @(negedge clk) begin
        if (wr_uart === 1'b1) fifo_q.push_back(w_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]          = v;
        req_data[i*DW +: DW]  = d;
        req_last[i]           = l;
    endtask

    initial begin
        // ---------------- reset values ----------------
        repeat (3) tick();
        mid();
        check("rst_wr_uart", wr_uart, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_w_data", w_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        tick();
        reset = 1'b0;

        // ---------------- 1: three-byte packet from requester 1 ----------------
        set_req(1, 1'b1, 8'hA1, 1'b0);
        mid();
        check("t1_idle_wr", wr_uart, 0);
        check("t1_idle_busy", busy, 0);
        tick(); mid();
        check("t1_grant", grant_id, 1);
        check("t1_busy", busy, 1);
        check("t1_ready", req_ready, 4'b0010);
        check("t1_wr_a1", wr_uart, 1);
        check("t1_data_a1", w_data, 8'hA1);
        tick(); set_req(1, 1'b1, 8'hA2, 1'b0); mid();
        check("t1_wr_a2", wr_uart, 1);
        check("t1_data_a2", w_data, 8'hA2);
        tick(); set_req(1, 1'b1, 8'hA3, 1'b1); mid();
        check("t1_wr_a3", wr_uart, 1);
        check("t1_data_a3", w_data, 8'hA3);
        tick(); set_req(1, 1'b0, 8'h00, 1'b0); mid();
        check("t1_done_busy", busy, 0);
        check("t1_done_wr", wr_uart, 0);
        check("t1_grant_hold", grant_id, 1);
        tick();
        check("t1_fifo_len", fifo_q.size(), 3);
        check("t1_fifo_data", {fifo_q[0], fifo_q[1], fifo_q[2]}, 24'hA1A2A3);
        fifo_q.delete();

        // ---------------- 2: four 1-byte packets, rotation after reset ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            mid();
            check("t2_wr_pattern", wr_uart, c % 2);
            if (c % 2 == 1) check("t2_rr_data", w_data, 8'h10 + ((c / 2) % 4));
        end
        tick();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 1'b0);
        mid();
        check("t2_idle_after", wr_uart, 0);
        tick();
        check("t2_fifo_len", fifo_q.size(), 5);
        check("t2_fifo_data", {fifo_q[0], fifo_q[1], fifo_q[2], fifo_q[3], fifo_q[4]},
              40'h1011121310);
        fifo_q.delete();

        // ---------------- 3: backpressure inside requester 2's packet ----------------
        set_req(2, 1'b1, 8'hB0, 1'b0);
        mid();
        check("t3_idle_wr", wr_uart, 0);
        tick(); mid();
        check("t3_data_b0", w_data, 8'hB0);
        check("t3_wr_b0", wr_uart, 1);
        tick(); set_req(2, 1'b1, 8'hB1, 1'b0); mid();
        check("t3_data_b1", w_data, 8'hB1);
        tick(); set_req(2, 1'b1, 8'hB2, 1'b0); tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            mid();
            check("t3_full_wr", wr_uart, 0);
            check("t3_full_ready", req_ready, 0);
            check("t3_full_busy", busy, 1);
        end
        tick(); tx_full = 1'b0; mid();
        check("t3_wr_b2", wr_uart, 1);
        check("t3_data_b2", w_data, 8'hB2);
        tick(); set_req(2, 1'b1, 8'hB3, 1'b1); mid();
        check("t3_data_b3", w_data, 8'hB3);
        tick(); set_req(2, 1'b0, 8'h00, 1'b0); mid();
        check("t3_done_busy", busy, 0);
        tick();
        check("t3_fifo_len", fifo_q.size(), 4);
        check("t3_fifo_data", {fifo_q[0], fifo_q[1], fifo_q[2], fifo_q[3]}, 32'hB0B1B2B3);
        fifo_q.delete();

        // ---------------- 4: non-owner valid while locked ----------------
        set_req(2, 1'b1, 8'hC0, 1'b0);
        tick(); mid();
        check("t4_grant2", grant_id, 2);
        check("t4_data_c0", w_data, 8'hC0);
        tick(); set_req(2, 1'b1, 8'hC1, 1'b0); set_req(0, 1'b1, 8'hD0, 1'b1); mid();
        check("t4_ready_c1", req_ready, 4'b0100);
        check("t4_data_c1", w_data, 8'hC1);
        tick(); set_req(2, 1'b1, 8'hC2, 1'b1); mid();
        check("t4_ready_c2", req_ready, 4'b0100);
        check("t4_data_c2", w_data, 8'hC2);
        tick(); set_req(2, 1'b0, 8'h00, 1'b0); mid();
        check("t4_arb_busy", busy, 0);
        check("t4_arb_ready", req_ready, 0);
        check("t4_arb_grant_hold", grant_id, 2);
        tick(); mid();
        check("t4_grant0", grant_id, 0);
        check("t4_ready0", req_ready, 4'b0001);
        check("t4_data_d0", w_data, 8'hD0);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0); mid();
        check("t4_done_busy", busy, 0);

        // ---------------- 5: reset in the middle of requester 3's packet ----------------
        tick(); set_req(3, 1'b1, 8'hE0, 1'b0);
        tick(); mid();
        check("t5_grant3", grant_id, 3);
        check("t5_data_e0", w_data, 8'hE0);
        tick(); reset = 1'b1; set_req(3, 1'b1, 8'hE1, 1'b0);
        tick(); reset = 1'b0; set_req(0, 1'b1, 8'hF0, 1'b1); mid();
        check("t5_rst_wr", wr_uart, 0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_grant", grant_id, 0);
        tick(); mid();
        check("t5_winner0", grant_id, 0);
        check("t5_ready0", req_ready, 4'b0001);
        check("t5_data_f0", w_data, 8'hF0);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0); set_req(3, 1'b0, 8'h00, 1'b0); mid();
        check("t5_done_busy", busy, 0);

`ifdef UART_ARB_TIMEOUT_EN
        // ---------------- 6: silent owner released by timeout ----------------
        tick(); set_req(1, 1'b1, 8'h55, 1'b0);
        tick(); mid();
        check("t6_grant1", grant_id, 1);
        check("t6_data_55", w_data, 8'h55);
        tick(); set_req(1, 1'b0, 8'h00, 1'b0); set_req(2, 1'b1, 8'h66, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            mid();
            check("t6_wait_evt", timeout_evt, 0);
            check("t6_wait_busy", busy, 1);
            check("t6_wait_ready", req_ready, 4'b0010);
        end
        tick(); mid();
        check("t6_evt", timeout_evt, 1);
        check("t6_evt_busy", busy, 0);
        tick(); mid();
        check("t6_evt_clear", timeout_evt, 0);
        check("t6_grant2", grant_id, 2);
        check("t6_data_66", w_data, 8'h66);
        tick(); set_req(2, 1'b0, 8'h00, 1'b0); mid();
        check("t6_done_busy", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
